// File: rtl/sha3_stream_checker.sv
// Pattern streamer and golden-digest checker that sits beside the SHA3 core.
// Build macro SHA3_CHK_LENMASK_EN: when defined, only digest bits below core_out_len are compared.
module sha3_stream_checker #(
    parameter int N_PAT   = 48,
    parameter int N_GOLD  = 48,
    parameter int N_MSG   = 8,
    parameter int DIN_W   = 6400,
    parameter int DOUT_W  = 1344,
    parameter int LEN_W   = 13,
    parameter int TIMEOUT = 100,
    parameter int IDX_W   = 6,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [IDX_W-1:0]  pat_idx,
    input  logic [DIN_W-1:0]  pat_data,
    input  logic [10:0]       pat_inlen,
    input  logic [10:0]       pat_outlen,
    input  logic [1:0]        pat_mode,
    input  logic              pat_fin,
    output logic [DIN_W-1:0]  core_data_in,
    output logic [LEN_W-1:0]  core_data_len,
    output logic [LEN_W-1:0]  core_length,
    output logic [1:0]        core_mode,
    output logic              core_in_finish,
    output logic              core_in_valid,
    input  logic              core_in_ready,
    input  logic [DOUT_W-1:0] core_data_out,
    input  logic              core_out_valid,
    input  logic [10:0]       core_out_len,
    input  logic              core_finish,
    output logic [IDX_W-1:0]  gold_idx,
    input  logic [DOUT_W-1:0] gold_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  score,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [1:0]        dbg_state
);

    // Handshake: a word moves on every clock edge where core_in_valid && core_in_ready;
    // once valid is raised, valid and all core_* fields stay fixed until that edge.

    localparam int FIN_W = $clog2(N_MSG + 1);
    localparam int CYC_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] PAT_END  = IDX_W'(N_PAT);
    localparam logic [IDX_W-1:0] GOLD_END = IDX_W'(N_GOLD);
    localparam logic [FIN_W-1:0] FIN_END  = FIN_W'(N_MSG);
    localparam logic [CYC_W-1:0] CYC_END  = CYC_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [FIN_W-1:0] fin_cnt;
    logic [CYC_W-1:0] cyc;

    logic running;
    logic start_run;
    logic xfer;
    logic load_word;
    logic last_xfer;
    logic complete;
    logic expired;
    logic out_chk;
    logic gold_full;
    logic cmp_eq;

    logic [CNT_W-1:0] score_d, err_d;
    logic [IDX_W-1:0] gold_d, ferr_d;

    assign running   = (state_q == S_DRIVE) || (state_q == S_DRAIN);
    assign start_run = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign xfer      = core_in_valid && core_in_ready;
    // pat_idx addresses the next word to load, so the slot refills on the transfer edge.
    assign load_word = (state_q == S_DRIVE) && (pat_idx < PAT_END) && (!core_in_valid || core_in_ready);
    assign last_xfer = xfer && (pat_idx == PAT_END);
    assign complete  = running && (fin_cnt == FIN_END);
    assign expired   = running && (cyc == CYC_END);
    assign out_chk   = running && core_out_valid;
    assign gold_full = (gold_idx == GOLD_END);
    assign dbg_state = state_q;

`ifdef SHA3_CHK_LENMASK_EN
    logic [DOUT_W-1:0] len_mask;

    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < DOUT_W; i++) begin
            len_mask[i] = (i < 32'(core_out_len));
        end
    end

    assign cmp_eq = (((core_data_out ^ gold_data) & len_mask) == '0);
`else
    logic unused_out_len;
    assign unused_out_len = ^core_out_len;
    assign cmp_eq = (core_data_out == gold_data);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_DRIVE;
            S_DRIVE: begin
                if (complete || expired) state_d = S_DONE;
                else if (last_xfer)      state_d = S_DRAIN;
            end
            S_DRAIN: if (complete || expired) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_DRIVE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next-cycle checker counters; pass is judged on these so a compare in the
    // deciding cycle is already included.
    always_comb begin
        score_d = score;
        err_d   = err_cnt;
        gold_d  = gold_idx;
        ferr_d  = first_err_idx;
        if (out_chk) begin
            if (!gold_full && cmp_eq) begin
                if (score != '1) score_d = score + CNT_W'(1);
            end else begin
                if (err_cnt == '0) ferr_d = gold_idx;
                if (err_cnt != '1) err_d = err_cnt + CNT_W'(1);
            end
            if (!gold_full) gold_d = gold_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            pat_idx        <= '0;
            gold_idx       <= '0;
            core_data_in   <= '0;
            core_data_len  <= '0;
            core_length    <= '0;
            core_mode      <= '0;
            core_in_finish <= 1'b0;
            core_in_valid  <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            score          <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            fin_cnt        <= '0;
            cyc            <= '0;
        end else begin
            state_q <= state_d;
            if (start_run) begin
                pat_idx       <= '0;
                gold_idx      <= '0;
                core_in_valid <= 1'b0;
                done          <= 1'b0;
                pass          <= 1'b0;
                timeout       <= 1'b0;
                score         <= '0;
                err_cnt       <= '0;
                first_err_idx <= '0;
                fin_cnt       <= '0;
                cyc           <= '0;
            end else if (running) begin
                score         <= score_d;
                err_cnt       <= err_d;
                gold_idx      <= gold_d;
                first_err_idx <= ferr_d;
                if (core_out_valid && core_finish && (fin_cnt != FIN_END)) begin
                    fin_cnt <= fin_cnt + FIN_W'(1);
                end
                if (cyc != CYC_END) cyc <= cyc + CYC_W'(1);

                if (load_word) begin
                    core_data_in   <= pat_data;
                    core_data_len  <= LEN_W'({pat_inlen, 3'b000});
                    core_length    <= LEN_W'({pat_outlen, 3'b000});
                    core_mode      <= pat_mode;
                    core_in_finish <= pat_fin;
                    core_in_valid  <= 1'b1;
                    pat_idx        <= pat_idx + IDX_W'(1);
                end else if (xfer) begin
                    core_in_valid <= 1'b0;
                end

                // Completion outranks a timeout that lands in the same cycle.
                if (complete || expired) begin
                    done          <= 1'b1;
                    timeout       <= !complete;
                    pass          <= complete && (err_d == '0) && (score_d != '0);
                    core_in_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha3_stream_checker.sv
// Bench for sha3_stream_checker: async ROM models, a scripted core stand-in and a word scoreboard.
module tb_sha3_stream_checker;

    localparam int N_PAT   = 8;
    localparam int N_GOLD  = 8;
    localparam int N_MSG   = 8;
    localparam int DIN_W   = 64;
    localparam int DOUT_W  = 512;
    localparam int LEN_W   = 13;
    localparam int TIMEOUT = 100;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 8;
    localparam int XW      = DIN_W + 2 * LEN_W + 3;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic              clk, rst, start;
    logic [IDX_W-1:0]  pat_idx;
    logic [DIN_W-1:0]  pat_data;
    logic [10:0]       pat_inlen, pat_outlen;
    logic [1:0]        pat_mode;
    logic              pat_fin;
    logic [DIN_W-1:0]  core_data_in;
    logic [LEN_W-1:0]  core_data_len, core_length;
    logic [1:0]        core_mode;
    logic              core_in_finish, core_in_valid, core_in_ready;
    logic [DOUT_W-1:0] core_data_out;
    logic              core_out_valid;
    logic [10:0]       core_out_len;
    logic              core_finish;
    logic [IDX_W-1:0]  gold_idx;
    logic [DOUT_W-1:0] gold_data;
    logic              done, pass, timeout;
    logic [CNT_W-1:0]  score, err_cnt;
    logic [IDX_W-1:0]  first_err_idx;
    logic [1:0]        dbg_state;

    logic [DIN_W-1:0]  rom_data   [N_PAT];
    logic [10:0]       rom_inlen  [N_PAT];
    logic [10:0]       rom_outlen [N_PAT];
    logic [1:0]        rom_mode   [N_PAT];
    logic              rom_fin    [N_PAT];
    logic [DOUT_W-1:0] gold_rom   [N_GOLD];

    int n_checks, n_pass;
    logic [XW-1:0] exp_q[$];
    logic [XW-1:0] obs_word;
    bit mon_en;
    int m_gidx, m_score, m_err, m_first;

    sha3_stream_checker #(
        .N_PAT(N_PAT), .N_GOLD(N_GOLD), .N_MSG(N_MSG), .DIN_W(DIN_W), .DOUT_W(DOUT_W),
        .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pat_idx(pat_idx), .pat_data(pat_data), .pat_inlen(pat_inlen), .pat_outlen(pat_outlen),
        .pat_mode(pat_mode), .pat_fin(pat_fin),
        .core_data_in(core_data_in), .core_data_len(core_data_len), .core_length(core_length),
        .core_mode(core_mode), .core_in_finish(core_in_finish), .core_in_valid(core_in_valid),
        .core_in_ready(core_in_ready), .core_data_out(core_data_out), .core_out_valid(core_out_valid),
        .core_out_len(core_out_len), .core_finish(core_finish),
        .gold_idx(gold_idx), .gold_data(gold_data),
        .done(done), .pass(pass), .timeout(timeout), .score(score), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached without the summary");
        $fatal(1, "watchdog expired");
    end

    // asynchronous-read ROMs
    assign pat_data   = (pat_idx < IDX_W'(N_PAT)) ? rom_data[pat_idx[2:0]]   : '0;
    assign pat_inlen  = (pat_idx < IDX_W'(N_PAT)) ? rom_inlen[pat_idx[2:0]]  : '0;
    assign pat_outlen = (pat_idx < IDX_W'(N_PAT)) ? rom_outlen[pat_idx[2:0]] : '0;
    assign pat_mode   = (pat_idx < IDX_W'(N_PAT)) ? rom_mode[pat_idx[2:0]]   : '0;
    assign pat_fin    = (pat_idx < IDX_W'(N_PAT)) ? rom_fin[pat_idx[2:0]]    : 1'b0;
    assign gold_data  = (gold_idx < IDX_W'(N_GOLD)) ? gold_rom[gold_idx[2:0]] : '0;

    // scoreboard: every accepted input word must be the next expected one
    assign obs_word = {core_data_in, core_data_len, core_length, core_mode, core_in_finish};

    always @(negedge clk) begin
        if (mon_en && core_in_valid && core_in_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL xfer_extra: observed word %h, expected none", obs_word);
            end else if (obs_word !== exp_q[0]) begin
                $display("FAIL xfer_word: observed %h, expected %h", obs_word, exp_q[0]);
                exp_q.delete(0);
            end else begin
                n_pass++;
                exp_q.delete(0);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run();
        exp_q.delete();
        for (int i = 0; i < N_PAT; i++) begin
            int dl, ol;
            dl = (int'(rom_inlen[i]) * 8) % (1 << LEN_W);
            ol = (int'(rom_outlen[i]) * 8) % (1 << LEN_W);
            exp_q.push_back({rom_data[i], LEN_W'(dl), LEN_W'(ol), rom_mode[i], rom_fin[i]});
        end
    endtask

    task automatic model_clear();
        m_gidx = 0; m_score = 0; m_err = 0; m_first = 0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic emit_out(input logic [DOUT_W-1:0] d, input logic fin, input logic [10:0] len);
        logic [DOUT_W-1:0] msk;
        bit eq_full, eq_mask, eq;
        core_data_out  = d;
        core_out_valid = 1'b1;
        core_finish    = fin;
        core_out_len   = len;
        msk = (int'(len) >= DOUT_W) ? '1 : ((DOUT_W'(1) << len) - DOUT_W'(1));
        if (m_gidx >= N_GOLD) begin
            eq_full = 0;
            eq_mask = 0;
        end else begin
            eq_full = (d == gold_rom[m_gidx]);
            eq_mask = (((d ^ gold_rom[m_gidx]) & msk) == '0);
        end
`ifdef SHA3_CHK_LENMASK_EN
        eq = eq_mask;
`else
        eq = eq_full;
`endif
        if (eq) begin
            if (m_score < SAT) m_score++;
        end else begin
            if (m_err == 0) m_first = m_gidx;
            if (m_err < SAT) m_err++;
        end
        if (m_gidx < N_GOLD) m_gidx++;
        tick();
    endtask

    task automatic out_idle();
        core_out_valid = 1'b0;
        core_finish    = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b0; start = 1'b0; core_in_ready = 1'b0; mon_en = 0;
        core_data_out = '0; core_out_valid = 1'b0; core_out_len = '0; core_finish = 1'b0;
        tick(); tick();
        n_checks++;
        if ({done, pass, timeout} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {done, pass, timeout});
        else n_pass++;
        n_checks++;
        if ({score, err_cnt} !== '0) $display("FAIL reset_counts: got %h want 0", {score, err_cnt});
        else n_pass++;
        n_checks++;
        if ({pat_idx, gold_idx, first_err_idx} !== '0) $display("FAIL reset_idx: got %h want 0", {pat_idx, gold_idx, first_err_idx});
        else n_pass++;
        n_checks++;
        if ({core_in_valid, core_data_in, dbg_state} !== '0) $display("FAIL reset_core: got %h want 0", {core_in_valid, core_data_in, dbg_state});
        else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_pass();
        core_in_ready = 1'b1;
        model_clear(); push_run(); mon_en = 1;
        start_run();
        n_checks++;
        if ({dbg_state, core_in_valid, pat_idx} !== {2'd1, 1'b0, 4'd0})
            $display("FAIL enter_drive: got %h want %h", {dbg_state, core_in_valid, pat_idx}, {2'd1, 1'b0, 4'd0});
        else n_pass++;
        tick();
        n_checks++;
        if ({core_in_valid, pat_idx, core_data_in} !== {1'b1, 4'd1, rom_data[0]})
            $display("FAIL first_word: got %h want %h", {core_in_valid, pat_idx, core_data_in}, {1'b1, 4'd1, rom_data[0]});
        else n_pass++;
        repeat (10) tick();
        n_checks++;
        if (dbg_state !== 2'd2 || exp_q.size() != 0) $display("FAIL drained: state %0d left %0d want 2 and 0", dbg_state, exp_q.size());
        else n_pass++;
        for (int i = 0; i < N_GOLD; i++) emit_out(gold_rom[i], 1'b1, 11'd512);
        out_idle();
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_early: got %b want 0", done);
        else n_pass++;
        tick();
        n_checks++;
        if ({done, pass, timeout, dbg_state} !== {3'b110, 2'd3}) $display("FAIL full_flags: got %b want 11011", {done, pass, timeout, dbg_state});
        else n_pass++;
        n_checks++;
        if ({score, err_cnt, first_err_idx} !== {CNT_W'(m_score), CNT_W'(m_err), IDX_W'(m_first)})
            $display("FAIL full_counts: got %h want %h", {score, err_cnt, first_err_idx}, {CNT_W'(m_score), CNT_W'(m_err), IDX_W'(m_first)});
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [XW-1:0] snap;
        bit found;
        core_in_ready = 1'b1;
        model_clear(); push_run();
        start_run();
        n_checks++;
        if ({done, pass, timeout, score, err_cnt} !== '0) $display("FAIL restart_clear: got %h want 0", {done, pass, timeout, score, err_cnt});
        else n_pass++;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (core_in_valid && pat_idx == 4'd2) found = 1;
            else tick();
        end
        n_checks++;
        if (!found) $display("FAIL stall_point: got pat_idx %0d valid %b want 2 and 1", pat_idx, core_in_valid);
        else n_pass++;
        core_in_ready = 1'b0;
        snap = obs_word;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({obs_word, pat_idx, core_in_valid} !== {snap, 4'd2, 1'b1})
                $display("FAIL stall_hold: cycle %0d got %h want %h", c, {obs_word, pat_idx, core_in_valid}, {snap, 4'd2, 1'b1});
            else n_pass++;
        end
        for (int c = 0; c < 20; c++) begin
            core_in_ready = 1'($urandom_range(0, 1));
            tick();
        end
        core_in_ready = 1'b1;
        repeat (12) tick();
        n_checks++;
        if (exp_q.size() != 0 || dbg_state !== 2'd2) $display("FAIL bp_drained: left %0d state %0d want 0 and 2", exp_q.size(), dbg_state);
        else n_pass++;
        for (int i = 0; i < N_GOLD; i++) emit_out(gold_rom[i], 1'b1, 11'd512);
        out_idle();
        tick();
        n_checks++;
        if ({done, pass, score} !== {2'b11, CNT_W'(m_score)}) $display("FAIL bp_result: got %h want %h", {done, pass, score}, {2'b11, CNT_W'(m_score)});
        else n_pass++;
    endtask

    task automatic test_gold_error();
        logic [DOUT_W-1:0] saved;
        saved = gold_rom[5];
        gold_rom[5] = saved ^ DOUT_W'(1);
        core_in_ready = 1'b1;
        model_clear(); push_run();
        start_run();
        repeat (11) tick();
        core_finish = 1'b1;
        tick();
        core_finish = 1'b0;
        for (int i = 0; i < N_GOLD; i++) emit_out((i == 5) ? saved : gold_rom[i], 1'b1, 11'd512);
        out_idle();
        n_checks++;
        if (done !== 1'b0) $display("FAIL finish_no_valid: done got %b want 0", done);
        else n_pass++;
        tick();
        n_checks++;
        if ({done, pass, timeout} !== 3'b100) $display("FAIL err_flags: got %b want 100", {done, pass, timeout});
        else n_pass++;
        n_checks++;
        if ({score, err_cnt, first_err_idx} !== {CNT_W'(m_score), CNT_W'(m_err), IDX_W'(m_first)})
            $display("FAIL err_counts: got %h want %h", {score, err_cnt, first_err_idx}, {CNT_W'(m_score), CNT_W'(m_err), IDX_W'(m_first)});
        else n_pass++;
        gold_rom[5] = saved;
    endtask

    task automatic test_gold_overflow();
        core_in_ready = 1'b1;
        model_clear(); push_run();
        start_run();
        repeat (11) tick();
        for (int i = 0; i < N_GOLD; i++) emit_out(gold_rom[i], 1'b0, 11'd512);
        for (int i = 0; i < N_MSG; i++) emit_out(gold_rom[i], 1'b1, 11'd512);
        out_idle();
        tick();
        n_checks++;
        if (gold_idx !== IDX_W'(N_GOLD)) $display("FAIL gold_hold: got %0d want %0d", gold_idx, N_GOLD);
        else n_pass++;
        n_checks++;
        if ({done, pass, timeout} !== 3'b100) $display("FAIL ovf_flags: got %b want 100", {done, pass, timeout});
        else n_pass++;
        n_checks++;
        if ({score, err_cnt, first_err_idx} !== {CNT_W'(m_score), CNT_W'(m_err), IDX_W'(m_first)})
            $display("FAIL ovf_counts: got %h want %h", {score, err_cnt, first_err_idx}, {CNT_W'(m_score), CNT_W'(m_err), IDX_W'(m_first)});
        else n_pass++;
    endtask

    task automatic test_timeout();
        core_in_ready = 1'b1;
        model_clear(); push_run();
        start_run();
        repeat (TIMEOUT) tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL timeout_early: done got %b want 0", done);
        else n_pass++;
        tick();
        n_checks++;
        if ({done, pass, timeout, dbg_state} !== {3'b101, 2'd3}) $display("FAIL timeout_flags: got %b want 10111", {done, pass, timeout, dbg_state});
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        core_in_ready = 1'b1;
        model_clear(); push_run();
        start_run();
        repeat (3) tick();
        emit_out(~gold_rom[0], 1'b0, 11'd512);
        out_idle();
        mon_en = 0;
        rst = 1'b0; start = 1'b1;
        tick();
        n_checks++;
        if ({done, pass, timeout, score, err_cnt, first_err_idx} !== '0)
            $display("FAIL midrst_status: got %h want 0", {done, pass, timeout, score, err_cnt, first_err_idx});
        else n_pass++;
        n_checks++;
        if ({pat_idx, gold_idx, core_in_valid, dbg_state} !== '0) $display("FAIL midrst_ctrl: got %h want 0", {pat_idx, gold_idx, core_in_valid, dbg_state});
        else n_pass++;
        rst = 1'b1; start = 1'b0;
        tick();
        n_checks++;
        if (dbg_state !== 2'd0) $display("FAIL midrst_idle: got %0d want 0", dbg_state);
        else n_pass++;
        model_clear(); push_run(); mon_en = 1;
        start_run();
        tick();
        n_checks++;
        if ({core_in_valid, pat_idx, core_data_in} !== {1'b1, 4'd1, rom_data[0]})
            $display("FAIL redrive: got %h want %h", {core_in_valid, pat_idx, core_data_in}, {1'b1, 4'd1, rom_data[0]});
        else n_pass++;
        repeat (10) tick();
        for (int i = 0; i < N_GOLD; i++) emit_out(gold_rom[i], 1'b1, 11'd512);
        out_idle();
        tick();
        n_checks++;
        if ({done, pass, score} !== {2'b11, CNT_W'(m_score)}) $display("FAIL redrive_result: got %h want %h", {done, pass, score}, {2'b11, CNT_W'(m_score)});
        else n_pass++;
    endtask

    task automatic test_lenmask();
        logic [DOUT_W-1:0] f300, f100;
        f300 = '0; f300[300] = 1'b1;
        f100 = '0; f100[100] = 1'b1;
        core_in_ready = 1'b1;
        model_clear(); push_run();
        start_run();
        repeat (11) tick();
        emit_out(gold_rom[0] ^ f300, 1'b1, 11'd256);
        emit_out(gold_rom[1] ^ f100, 1'b1, 11'd256);
        for (int i = 2; i < N_GOLD; i++) emit_out(gold_rom[i], 1'b1, 11'd512);
        out_idle();
        tick();
        n_checks++;
        if ({score, err_cnt, first_err_idx} !== {CNT_W'(m_score), CNT_W'(m_err), IDX_W'(m_first)})
            $display("FAIL lenmask_counts: got %h want %h", {score, err_cnt, first_err_idx}, {CNT_W'(m_score), CNT_W'(m_err), IDX_W'(m_first)});
        else n_pass++;
        n_checks++;
        if ({done, pass} !== 2'b10) $display("FAIL lenmask_flags: got %b want 10", {done, pass});
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; mon_en = 0;
        for (int i = 0; i < N_PAT; i++) begin
            rom_data[i]   = {$urandom, $urandom};
            rom_inlen[i]  = 11'($urandom_range(0, 2047));
            rom_outlen[i] = 11'($urandom_range(0, 2047));
            rom_mode[i]   = 2'($urandom_range(0, 3));
            rom_fin[i]    = (i == N_PAT - 1);
        end
        rom_inlen[3]  = 11'd1100;
        rom_outlen[4] = 11'd2047;
        for (int i = 0; i < N_GOLD; i++) begin
            for (int j = 0; j < DOUT_W / 32; j++) gold_rom[i][j*32 +: 32] = $urandom;
        end

        test_reset();
        test_full_pass();
        test_back_pressure();
        test_gold_error();
        test_gold_overflow();
        test_timeout();
        test_reset_mid_run();
        test_lenmask();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
